// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sequencer state encoding, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_W  = 3;
  localparam int OP_W   = 4;
  // Queued command: {op, rd, rs1, lo}; lo carries imm for LDI, else rs2.
  localparam int CMD_W  = OP_W + 2 * REG_W + DATA_W;

  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_INC   = 4'b1000;
  localparam logic [OP_W-1:0] OP_DEC   = 4'b1001;
  localparam logic [OP_W-1:0] OP_NOR   = 4'b1010;
  localparam logic [OP_W-1:0] OP_CMP   = 4'b1011;
  localparam logic [OP_W-1:0] OP_PASSA = 4'b1100;
  localparam logic [OP_W-1:0] OP_PASSB = 4'b1101;
  localparam logic [OP_W-1:0] OP_LDI   = 4'b1110;
  localparam logic [OP_W-1:0] OP_NOP   = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } seq_state_t;

  // CMP only sets flags and NOP does nothing; everything else writes rd.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return !((op == OP_CMP) || (op == OP_NOP));
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, registered storage, no fall-through.
// Latency: entry pushed at edge N is visible on dout from edge N+1.
// Backpressure: push ignored when full, pop ignored when empty; full/count do not look at same-cycle pop.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/write-back sequencer around the combinational 8-bit ALU, with 8x8 register file and bypass.
// Latency: push at edge N, issue at N+1, write-back and flags at N+2; one command per cycle sustained.
// Backpressure: cmd_ready low when the FIFO holds DEPTH entries or in reset; stall freezes issue/write-back.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREG  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic [7:0]  cmd_imm,
  input  logic        stall,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_o,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [7:0]  wb_data,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_o,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CMD_W-1:0]  fifo_din;
  logic [CMD_W-1:0]  fifo_dout;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full_unused;

  logic [DATA_W-1:0] rf [NREG];
  seq_state_t        state;
  logic [REG_W-1:0]  pend_rd;
  logic              pend_wr;
  logic              pend_flg;

  logic [OP_W-1:0]   hd_op;
  logic [REG_W-1:0]  hd_rd;
  logic [REG_W-1:0]  hd_rs1;
  logic [REG_W-1:0]  hd_rs2;
  logic [DATA_W-1:0] hd_lo;
  logic              byp_act;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [OP_W-1:0]   iss_sel;

  // Ready is purely occupancy based, so a same-cycle pop never frees a slot early.
  assign cmd_ready = !rst && (fifo_count < CNT_FULL);
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = !rst && !stall && !fifo_empty;
  assign fifo_full_unused = fifo_full;

  // LDI reuses the rs2/imm slot for its 8-bit immediate.
  assign fifo_din = {cmd_op, cmd_rd, cmd_rs1,
                     (cmd_op == OP_LDI) ? cmd_imm : {{(DATA_W-REG_W){1'b0}}, cmd_rs2}};

  assign {hd_op, hd_rd, hd_rs1, hd_lo} = fifo_dout;
  assign hd_rs2   = hd_lo[REG_W-1:0];
  assign dbg_data = rf[dbg_addr];

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Operand fetch for the FIFO head, forwarding the in-flight result when it targets a source.
  always_comb begin
    byp_act = (state == EXEC) && pend_wr;
    iss_a   = (byp_act && (hd_rs1 == pend_rd)) ? alu_out : rf[hd_rs1];
    iss_b   = (byp_act && (hd_rs2 == pend_rd)) ? alu_out : rf[hd_rs2];
    iss_sel = hd_op;
    if (hd_op == OP_LDI) begin
      iss_sel = OP_PASSB;
      iss_b   = hd_lo;
    end
  end

  // Sequencer: retire the in-flight op (write-back/flags) and issue the next head in the same edge.
  always_ff @(posedge clk) begin
    wb_valid <= 1'b0;
    if (rst) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      pend_rd  <= '0;
      pend_wr  <= 1'b0;
      pend_flg <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_o   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (!stall) begin
      if (state == EXEC) begin
        if (pend_wr) begin
          rf[pend_rd] <= alu_out;
          wb_valid    <= 1'b1;
          wb_rd       <= pend_rd;
          wb_data     <= alu_out;
        end
        if (pend_flg) begin
          flag_z <= alu_z;
          flag_c <= alu_c;
          flag_o <= alu_o;
        end
      end
      if (!fifo_empty) begin
        alu_a    <= iss_a;
        alu_b    <= iss_b;
        alu_sel  <= iss_sel;
        pend_rd  <= hd_rd;
        pend_wr  <= op_writes(hd_op);
        pend_flg <= (hd_op != OP_NOP);
        state    <= EXEC;
      end else begin
        state    <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq with a behavioural ALU and an in-order architectural scoreboard.
// Latency: expected write-backs queued at push, popped at each wb_valid pulse.
// Backpressure: pushes wait on cmd_ready with a bounded loop; stall driven directly.
module tb_alu_issue_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [2:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic       stall;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic       alu_z, alu_c, alu_o;
  logic       wb_valid;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_z, flag_c, flag_o;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  alu_issue_seq #(.DEPTH(4), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .stall(stall),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_z(alu_z), .alu_c(alu_c), .alu_o(alu_o),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .flag_o(flag_o),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: returns {z, c, o, result}.
  function automatic logic [10:0] alu_f(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, o;
    w = 9'd0; r = 8'd0; c = 1'b0; o = 1'b0;
    case (sel)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB, OP_CMP: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_SHL:   begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR:   begin r = {1'b0, a[7:1]}; c = a[0]; end
      OP_INC:   begin w = {1'b0, a} + 9'd1; r = w[7:0]; c = w[8]; o = (a == 8'h7F); end
      OP_DEC:   begin w = {1'b0, a} - 9'd1; r = w[7:0]; c = w[8]; o = (a == 8'h80); end
      OP_NOR:   r = ~(a | b);
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      default:  r = 8'h00;
    endcase
    return {(r == 8'h00), c, o, r};
  endfunction

  assign {alu_z, alu_c, alu_o, alu_out} = alu_f(alu_sel, alu_a, alu_b);

  // Scoreboard state
  logic [7:0]  mrf [8];
  logic        mz, mc, mo;
  logic [10:0] exp_q [$];
  logic [10:0] mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wb = 0;
  int          cyc = 0;
  int          wb_cyc_prev = 0;
  int          wb_cyc_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    {mz, mc, mo} = 3'b000;
    exp_q.delete();
  endtask

  // Offer one command from the current negedge; returns at the negedge after it is taken.
  task automatic push_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic [7:0] imm);
    int          t;
    logic [10:0] r;
    t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      if (op == OP_LDI) r = alu_f(OP_PASSB, 8'h00, imm);
      else              r = alu_f(op, mrf[rs1], mrf[rs2]);
      if (op != OP_NOP) {mz, mc, mo} = r[10:8];
      if (op != OP_NOP && op != OP_CMP) begin
        mrf[rd] = r[7:0];
        exp_q.push_back({rd, r[7:0]});
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("flag_z", 32'(flag_z), 32'(mz));
    chk("flag_c", 32'(flag_c), 32'(mc));
    chk("flag_o", 32'(flag_o), 32'(mo));
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) chk_reg(tag, 3'(i), 8'h00);
    chk({tag, "_a"},    32'(alu_a),    32'd0);
    chk({tag, "_b"},    32'(alu_b),    32'd0);
    chk({tag, "_sel"},  32'(alu_sel),  32'd0);
    chk({tag, "_fl"},   32'({flag_z, flag_c, flag_o}), 32'd0);
    chk({tag, "_wbv"},  32'(wb_valid), 32'd0);
    chk({tag, "_wbrd"}, 32'(wb_rd),    32'd0);
    chk({tag, "_wbd"},  32'(wb_data),  32'd0);
  endtask

  always @(posedge clk) cyc++;

  // Write-back monitor: every pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (wb_valid) begin
      n_wb++;
      wb_cyc_prev = wb_cyc_last;
      wb_cyc_last = cyc;
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd",   32'(wb_rd),   32'(mon_e[10:8]));
        chk("wb_data", 32'(wb_data), 32'(mon_e[7:0]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_wb_save;
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    cmd_imm = 8'h00; stall = 1'b0; dbg_addr = 3'd0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // LDI latency, then LDI/ADD
    @(negedge clk);
    push_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h14);
    chk("lat_n0", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("lat_n1", 32'(wb_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2", 32'(wb_valid), 32'd1);
    push_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h05);
    push_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    drain();
    chk_reg("add_r3", 3'd3, 8'h19);
    chk("add_flags", 32'({flag_z, flag_c, flag_o}), 32'd0);

    // Back-to-back with rs1 bypass, then rs2 bypass behind an LDI
    push_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    push_cmd(OP_SUB, 3'd4, 3'd3, 3'd2, 8'h00);
    drain();
    chk("b2b_gap", 32'(wb_cyc_last - wb_cyc_prev), 32'd1);
    chk_reg("sub_r4", 3'd4, 8'h14);
    push_cmd(OP_LDI, 3'd6, 3'd0, 3'd0, 8'h0F);
    push_cmd(OP_OR,  3'd7, 3'd0, 3'd6, 8'h00);
    drain();
    chk("b2b_gap2", 32'(wb_cyc_last - wb_cyc_prev), 32'd1);
    chk_reg("or_r7", 3'd7, 8'h0F);

    // Signed overflow
    push_cmd(OP_LDI, 3'd5, 3'd0, 3'd0, 8'h7F);
    push_cmd(OP_LDI, 3'd6, 3'd0, 3'd0, 8'h01);
    push_cmd(OP_ADD, 3'd7, 3'd5, 3'd6, 8'h00);
    drain();
    chk_reg("ovf_r7", 3'd7, 8'h80);
    chk("ovf_o", 32'(flag_o), 32'd1);

    // NOP: no write, flags untouched (ALU would report z=1 here)
    n_wb_save = n_wb;
    push_cmd(OP_NOP, 3'd2, 3'd0, 3'd0, 8'h00);
    drain();
    chk("nop_wb", 32'(n_wb), 32'(n_wb_save));
    chk("nop_flags", 32'({flag_z, flag_c, flag_o}), 32'b001);
    chk_reg("nop_r2", 3'd2, 8'h05);

    // CMP: flags only
    n_wb_save = n_wb;
    push_cmd(OP_CMP, 3'd7, 3'd5, 3'd5, 8'h00);
    drain();
    chk("cmp_wb", 32'(n_wb), 32'(n_wb_save));
    chk_reg("cmp_r7", 3'd7, 8'h80);
    chk("cmp_z", 32'(flag_z), 32'd1);

    // Full under stall, then a burst of write-backs
    stall = 1'b1;
    push_cmd(OP_LDI, 3'd0, 3'd0, 3'd0, 8'h11);
    push_cmd(OP_ADD, 3'd1, 3'd0, 3'd0, 8'h00);
    push_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h33);
    push_cmd(OP_SUB, 3'd3, 3'd1, 3'd0, 8'h00);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("full_hold", 32'(cmd_ready), 32'd0);
    chk("stall_wb", 32'(wb_valid), 32'd0);
    stall = 1'b0;
    #1;
    chk("full_pop_ready", 32'(cmd_ready), 32'd0);
    fork
      push_cmd(OP_XOR, 3'd4, 3'd2, 3'd3, 8'h00);
      begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!wb_valid && t < 10);
        chk("burst_start", 32'(wb_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("burst_cont", 32'(wb_valid), 32'd1);
        end
      end
    join
    drain();
    chk_reg("burst_r3", 3'd3, 8'h11);
    chk_reg("burst_r4", 3'd4, 8'h22);

    // Reset in the middle of EXEC, with a second command queued
    push_cmd(OP_LDI, 3'd5, 3'd0, 3'd0, 8'hAA);
    push_cmd(OP_LDI, 3'd6, 3'd0, 3'd0, 8'hBB);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
    chk_all_zero("mid_rst");
    repeat (5) @(negedge clk);
    chk("mid_rst_no_wb", 32'(exp_q.size()), 32'd0);
    chk_reg("mid_rst_r5", 3'd5, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
